code_sequencer: RTL



---
 rtl/code_seq_pkg.sv | 23 ++
 rtl/run_watchdog.sv | 26 ++
 rtl/code_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/code_seq_pkg.sv
// Shared types and constants for the code sequencer.
package code_seq_pkg;

   localparam int INSTR_W = 12;
   localparam int LINE_W  = 32;
   localparam int OP_W    = 4;

   localparam logic [OP_W-1:0] OP_END_DEFAULT = 4'hF;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_OVERFLOW = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_NO_PROG  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_RUN,
      S_STOP
   } state_t;

endpackage

// File: rtl/run_watchdog.sv
// Counts RUN cycles; expired flags the last permitted cycle.
module run_watchdog #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   // Cycle counter: held at zero outside RUN, counts while enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + 1'b1;
   end

   // High during the TIMEOUT_CYCLES-th enabled cycle.
   assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/code_sequencer.sv
// Loads a program into data_path code storage and runs the fetch pipeline
// until an end op, an index past the loaded length, or a timeout.
module code_sequencer
   import code_seq_pkg::*;
#(
   parameter int              MAX_LINES      = 1024,
   parameter int              TIMEOUT_CYCLES = 65535,
   parameter logic [OP_W-1:0] OP_END         = OP_END_DEFAULT
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_last,
   input  logic               start,
   input  logic               abort,
   output logic [LINE_W-1:0]  code_storage_write_interface_write_line,
   output logic [INSTR_W-1:0] code_storage_write_interface_write_data,
   output logic               code_storage_write_interface_is_write,
   output logic               code_storage_code_control_interface_reset,
   output logic               code_storage_code_control_interface_active,
   input  logic [LINE_W-1:0]  fetch_to_decode_register_code_index_out_interface_code_index,
   input  logic [OP_W-1:0]    parse_op_interface_op,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [1:0]         error_code,
   output logic [LINE_W-1:0]  program_length
);

   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(MAX_LINES - 1);

   state_t              state, next_state;
   logic [LINE_W-1:0]   wr_ptr;
   logic [LINE_W-1:0]   beat_line;
   logic                accept;
   logic                end_cond;
   logic                expired;

   // The first beat of a program always lands at line 0.
   assign beat_line = (state == S_LOAD) ? wr_ptr : '0;
   assign accept    = load_valid && load_ready && !abort &&
                      (state == S_IDLE || state == S_LOAD);
   assign end_cond  = (parse_op_interface_op == OP_END) ||
                      (fetch_to_decode_register_code_index_out_interface_code_index >= program_length);

   run_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .clear   (state != S_RUN),
      .enable  (state == S_RUN),
      .expired (expired)
   );

   // State register.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) state <= S_IDLE;
      else                state <= next_state;
   end

   // Next-state logic; abort overrides everything.
   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept)
                  next_state = (load_last || beat_line == LAST_LINE) ? S_IDLE : S_LOAD;
               else if (start && program_length != '0)
                  next_state = S_CLEAR;
            end
            S_LOAD:  if (accept && (load_last || beat_line == LAST_LINE)) next_state = S_IDLE;
            S_CLEAR: next_state = S_RUN;
            S_RUN:   if (end_cond || expired) next_state = S_STOP;
            S_STOP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
         endcase
      end
   end

   // Registered outputs decoded from the upcoming state so they line up
   // with the state they describe.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         load_ready                                 <= 1'b0;
         busy                                       <= 1'b0;
         code_storage_code_control_interface_reset  <= 1'b0;
         code_storage_code_control_interface_active <= 1'b0;
         done                                       <= 1'b0;
      end else begin
         load_ready                                 <= (next_state == S_IDLE) || (next_state == S_LOAD);
         busy                                       <= (next_state != S_IDLE);
         code_storage_code_control_interface_reset  <= (next_state == S_CLEAR);
         code_storage_code_control_interface_active <= (next_state == S_RUN);
         done                                       <= !abort && (state == S_RUN) && end_cond;
      end
   end

   // Write port: one registered write per accepted beat.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         code_storage_write_interface_is_write   <= 1'b0;
         code_storage_write_interface_write_line <= '0;
         code_storage_write_interface_write_data <= '0;
         wr_ptr                                  <= '0;
      end else begin
         code_storage_write_interface_is_write <= accept;
         if (accept) begin
            code_storage_write_interface_write_line <= beat_line;
            code_storage_write_interface_write_data <= load_data;
            wr_ptr                                  <= beat_line + 1'b1;
         end
      end
   end

   // Program length and sticky error status.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         program_length <= '0;
         error          <= 1'b0;
         error_code     <= ERR_NONE;
      end else if (abort) begin
         // A half-loaded program is unusable.
         if (state == S_LOAD) program_length <= '0;
      end else if (accept) begin
         error      <= 1'b0;
         error_code <= ERR_NONE;
         if (load_last) begin
            program_length <= beat_line + 1'b1;
         end else if (beat_line == LAST_LINE) begin
            program_length <= '0;
            error          <= 1'b1;
            error_code     <= ERR_OVERFLOW;
         end
      end else if (start && state == S_IDLE) begin
         error      <= (program_length == '0);
         error_code <= (program_length == '0) ? ERR_NO_PROG : ERR_NONE;
      end else if (state == S_RUN && !end_cond && expired) begin
         error      <= 1'b1;
         error_code <= ERR_TIMEOUT;
      end
   end

endmodule
